// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and EX operand forwarding.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdMem  = 2'b10;
  localparam logic [1:0] FwdWb   = 2'b01;
  localparam logic [1:0] SrcLoad = 2'b01;

  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       lwStall;

  // Shadow copies of the EX/MEM and MEM/WB destination tracking; those stages are never flushed.
  always_ff @(posedge clock) begin
    if (reset) begin
      RdM       <= 5'd0;
      RegWriteM <= 1'b0;
      RdW       <= 5'd0;
      RegWriteW <= 1'b0;
    end else begin
      RdM       <= RdE;
      RegWriteM <= RegWriteE;
      RdW       <= RdM;
      RegWriteW <= RegWriteM;
    end
  end

  function automatic logic [1:0] fwdSelect(input logic [4:0] rs,
                                           input logic [4:0] rdM, input logic wrM,
                                           input logic [4:0] rdW, input logic wrW);
    if (wrM && (rdM != 5'd0) && (rdM == rs))
      return FwdMem;
    else if (wrW && (rdW != 5'd0) && (rdW == rs))
      return FwdWb;
    else
      return FwdNone;
  endfunction

  assign lwStall = (ResultSrcE == SrcLoad) && RegWriteE && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // Stall and flush are independent; a simultaneous load-use and taken branch asserts both.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FwdNone;
    ForwardBE = FwdNone;
    if (!reset) begin
      StallF    = lwStall;
      StallD    = lwStall;
      FlushD    = PCSrcE;
      FlushE    = lwStall | PCSrcE;
      ForwardAE = fwdSelect(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwdSelect(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCount;
  logic [31:0] flushCount;

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount <= 32'd0;
      flushCount <= 32'd0;
    end else begin
      if (lwStall && (stallCount != 32'hFFFF_FFFF))
        stallCount <= stallCount + 32'd1;
      if (PCSrcE && (flushCount != 32'hFFFF_FFFF))
        flushCount <= flushCount + 32'd1;
    end
  end

  assign StallCnt = reset ? 32'd0 : stallCount;
  assign FlushCnt = reset ? 32'd0 : flushCount;
`else
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule
